counter_nb_mod: RTL and testbench
=================================

Name: counter_nb_mod

Overview:
- Parametrised N-bit synchronous up/down counter; next generation of the team's 4-bit mode counter.
- Adds configurable width and step, a programmable modulo limit (LIMIT), an explicit hold mode, and a selectable disable policy.
- Used as the general counting primitive for timers, address generators and cascaded counters in the datapath.
- Outputs: count Q, one-cycle rollover pulse RCO, and load indicator LOAD.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- STEP, 3, increment/decrement used by step modes; legal range 1..2^WIDTH-1.
- CLEAR_ON_DISABLE, 1, ENABLE=0 behaviour: 1 clears Q/RCO/LOAD to 0 (legacy); 0 holds Q and drives RCO=LOAD=0.

Ports:
- CLK  in  1  main clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset; overrides all other inputs.
- ENABLE  in  1  counter enable, active high.
- MODO  in  3  operating mode select (encodings below).
- D  in  WIDTH  parallel load value.
- LIMIT  in  WIDTH  modulo terminal value for modes 110/111.
- Q  out  WIDTH  registered count.
- RCO  out  1  registered rollover flag; high exactly one cycle per wrap event.
- LOAD  out  1  registered; high for the cycle after a load-mode edge.

Behaviour:
- All outputs are registers; every change is visible one CLK edge after the inputs are sampled.
- Priority: RESET > ENABLE > MODO.
- RESET=1 at an edge: Q=0, RCO=0, LOAD=0. Applies regardless of ENABLE or MODO, including mid-count.
- ENABLE=0, RESET=0, CLEAR_ON_DISABLE=1: Q=0, RCO=0, LOAD=0.
- ENABLE=0, RESET=0, CLEAR_ON_DISABLE=0: Q holds, RCO=0, LOAD=0.
- ENABLE=1, RESET=0: MODO selects the operation below. All arithmetic is WIDTH+1 bits wide. RCO is the extra bit (carry for up, borrow for down). Q is the low WIDTH bits, so it wraps modulo 2^WIDTH.
  - 000 up by 1: {RCO,Q} <= Q+1.
  - 001 down by 1: {RCO,Q} <= Q-1; RCO=1 only when Q was 0.
  - 010 up by STEP: {RCO,Q} <= Q+STEP.
  - 011 down by STEP: {RCO,Q} <= Q-STEP; RCO=1 when Q<STEP.
  - 100 load: Q <= D, RCO=0, LOAD=1.
  - 101 hold: Q holds, RCO=0.
  - 110 modulo up: if Q>=LIMIT then Q<=0, RCO=1; else Q<=Q+1, RCO=0. This gives a period of LIMIT+1. A Q already above LIMIT (e.g. after a load or LIMIT change) wraps to 0 on the next edge.
  - 111 modulo down: if Q==0 or Q>LIMIT then Q<=LIMIT, RCO=1; else Q<=Q-1, RCO=0.
- LOAD=1 only in the cycle after an edge with ENABLE=1, RESET=0, MODO=100. In all other cases LOAD=0.
- RCO is never sticky. It is 0 in any cycle without a wrap.
- Consecutive wraps (e.g. LIMIT=0 in mode 110) keep RCO high continuously.
- LIMIT=0 in mode 110: Q stays 0 and RCO=1 every enabled cycle.
- Mode changes take effect on the same edge; no internal state exists beyond Q, RCO and LOAD.
- MODO and D are sampled only at the edge. No combinational path from any input to any output.
- After power-up, outputs are undefined until the first RESET edge. The bench must apply RESET first.

Test Plan:
- WIDTH=8, STEP=3. RESET=1 for 2 cycles with ENABLE=1, MODO=000 -> Q=0x00, RCO=0, LOAD=0. Then RESET=0 for 3 cycles -> Q=1,2,3, RCO=0.
- Load D=0xFE (MODO=100), then MODO=000 for 3 edges -> LOAD=1 in cycle 1 only; Q=0xFE,0xFF,0x00,0x01; RCO=1 only in the cycle Q=0x00.
- Load D=0x01, then MODO=011 -> Q=0x01 then 0xFE with RCO=1 for exactly one cycle; next edge Q=0xFB, RCO=0.
- MODO=110, LIMIT=4, from Q=0 -> Q sequence 1,2,3,4,0,1; RCO=1 only when Q returns to 0. Load D=9, then MODO=110 -> next Q=0, RCO=1. MODO=111, LIMIT=4 from Q=2 -> 1,0,4 with RCO=1 at 4.
- CLEAR_ON_DISABLE=1: Q=0x05, ENABLE=0 -> Q=0 next edge. CLEAR_ON_DISABLE=0: Q=0x05, ENABLE=0 for 3 edges -> Q stays 0x05, RCO=0, LOAD=0. ENABLE=1, MODO=101 -> Q stays 0x05.
- Mid-count reset: Q=0xFF in MODO=000, assert RESET and ENABLE together at the wrap edge -> Q=0, RCO=0 (reset wins). Next cycle with RESET=0 -> Q=1.

Source files
------------

// File: rtl/counter_nb_mod.sv
// counter_nb_mod: parametrised synchronous up/down counter with step modes,
// a programmable modulo limit, an explicit hold mode and a selectable
// disable policy.
//
// Parameters
//   WIDTH            counter width in bits (2..32)
//   STEP             increment/decrement used by the step modes (1..2^WIDTH-1)
//   CLEAR_ON_DISABLE 1: ENABLE=0 clears Q/RCO/LOAD; 0: ENABLE=0 holds Q and
//                    drives RCO=LOAD=0
//
// Ports
//   CLK     in   1      rising-edge clock
//   RESET   in   1      synchronous active-high reset, overrides everything
//   ENABLE  in   1      counter enable, active high
//   MODO    in   3      mode select
//   D       in   WIDTH  parallel load value
//   LIMIT   in   WIDTH  terminal value for the modulo modes
//   Q       out  WIDTH  registered count
//   RCO     out  1      registered wrap flag (carry/borrow), one cycle per wrap
//   LOAD    out  1      registered, high the cycle after a load edge
module counter_nb_mod #(
  parameter int WIDTH            = 8,
  parameter int STEP             = 3,
  parameter bit CLEAR_ON_DISABLE = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [2:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             LOAD
);

  localparam logic [2:0] MODE_UP1   = 3'b000;
  localparam logic [2:0] MODE_DN1   = 3'b001;
  localparam logic [2:0] MODE_UPS   = 3'b010;
  localparam logic [2:0] MODE_DNS   = 3'b011;
  localparam logic [2:0] MODE_LOAD  = 3'b100;
  localparam logic [2:0] MODE_HOLD  = 3'b101;
  localparam logic [2:0] MODE_MODUP = 3'b110;
  localparam logic [2:0] MODE_MODDN = 3'b111;

  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  // The arithmetic runs one bit wider than Q; the extra bit is the
  // carry (up) or borrow (down) that becomes RCO.
  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] sum_up1;
  logic [WIDTH:0] sum_dn1;
  logic [WIDTH:0] sum_ups;
  logic [WIDTH:0] sum_dns;

  logic [WIDTH-1:0] q_next;
  logic             rco_next;
  logic             load_next;

  assign q_ext   = {1'b0, Q};
  assign sum_up1 = q_ext + ONE_EXT;
  assign sum_dn1 = q_ext - ONE_EXT;
  assign sum_ups = q_ext + STEP_EXT;
  assign sum_dns = q_ext - STEP_EXT;

  always_comb begin
    q_next    = Q;
    rco_next  = 1'b0;
    load_next = 1'b0;
    case (MODO)
      MODE_UP1: {rco_next, q_next} = sum_up1;
      MODE_DN1: {rco_next, q_next} = sum_dn1;
      MODE_UPS: {rco_next, q_next} = sum_ups;
      MODE_DNS: {rco_next, q_next} = sum_dns;
      MODE_LOAD: begin
        q_next    = D;
        load_next = 1'b1;
      end
      MODE_HOLD: q_next = Q;
      MODE_MODUP: begin
        // >= rather than == so a count already beyond LIMIT wraps at once.
        if (Q >= LIMIT) begin
          q_next   = '0;
          rco_next = 1'b1;
        end else begin
          q_next = sum_up1[WIDTH-1:0];
        end
      end
      MODE_MODDN: begin
        if ((Q == '0) || (Q > LIMIT)) begin
          q_next   = LIMIT;
          rco_next = 1'b1;
        end else begin
          q_next = sum_dn1[WIDTH-1:0];
        end
      end
      default: q_next = Q;
    endcase
  end

  // Register stage: priority RESET > ENABLE > MODO
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q    <= '0;
      RCO  <= 1'b0;
      LOAD <= 1'b0;
    end else if (!ENABLE) begin
      if (CLEAR_ON_DISABLE) begin
        Q <= '0;
      end
      RCO  <= 1'b0;
      LOAD <= 1'b0;
    end else begin
      Q    <= q_next;
      RCO  <= rco_next;
      LOAD <= load_next;
    end
  end

endmodule

// File: tb/tb_counter_nb_mod.sv
// Testbench for counter_nb_mod. Two instances share one stimulus stream:
// one clears on disable, the other holds. A behavioural model computes the
// expected outputs of both with plain integer arithmetic.
module tb_counter_nb_mod;

  localparam int WIDTH = 8;
  localparam int STEP  = 3;
  localparam int MODV  = 1 << WIDTH;

  logic             CLK;
  logic             RESET;
  logic             ENABLE;
  logic [2:0]       MODO;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] LIMIT;

  logic [WIDTH-1:0] q_clr, q_hld;
  logic             rco_clr, rco_hld;
  logic             load_clr, load_hld;

  int errors = 0;
  int checks = 0;

  counter_nb_mod #(.WIDTH(WIDTH), .STEP(STEP), .CLEAR_ON_DISABLE(1'b1)) u_clr (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .MODO(MODO), .D(D), .LIMIT(LIMIT),
    .Q(q_clr), .RCO(rco_clr), .LOAD(load_clr)
  );

  counter_nb_mod #(.WIDTH(WIDTH), .STEP(STEP), .CLEAR_ON_DISABLE(1'b0)) u_hld (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .MODO(MODO), .D(D), .LIMIT(LIMIT),
    .Q(q_hld), .RCO(rco_hld), .LOAD(load_hld)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: index 0 = clear-on-disable, 1 = hold-on-disable.
  int mq[2];
  int mr[2];
  int ml[2];
  bit model_valid = 1'b0;

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      int t;
      if (RESET) begin
        mq[k] = 0; mr[k] = 0; ml[k] = 0;
      end else if (!ENABLE) begin
        if (k == 0) mq[k] = 0;
        mr[k] = 0; ml[k] = 0;
      end else begin
        ml[k] = 0;
        case (MODO)
          3'd0: begin t = mq[k] + 1;    mr[k] = (t >= MODV); mq[k] = t % MODV; end
          3'd1: begin mr[k] = (mq[k] < 1);    mq[k] = (mq[k] - 1 + MODV) % MODV; end
          3'd2: begin t = mq[k] + STEP; mr[k] = (t >= MODV); mq[k] = t % MODV; end
          3'd3: begin mr[k] = (mq[k] < STEP); mq[k] = (mq[k] - STEP + MODV) % MODV; end
          3'd4: begin mq[k] = int'(D); mr[k] = 0; ml[k] = 1; end
          3'd5: mr[k] = 0;
          3'd6: begin
            if (mq[k] >= int'(LIMIT)) begin mq[k] = 0; mr[k] = 1; end
            else begin mq[k] = mq[k] + 1; mr[k] = 0; end
          end
          default: begin
            if (mq[k] == 0 || mq[k] > int'(LIMIT)) begin mq[k] = int'(LIMIT); mr[k] = 1; end
            else begin mq[k] = mq[k] - 1; mr[k] = 0; end
          end
        endcase
      end
    end
    if (RESET) model_valid = 1'b1;
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge CLK) begin
    if (model_valid) begin
      cmp("q_clr",    int'(q_clr),    mq[0]);
      cmp("rco_clr",  int'(rco_clr),  mr[0]);
      cmp("load_clr", int'(load_clr), ml[0]);
      cmp("q_hld",    int'(q_hld),    mq[1]);
      cmp("rco_hld",  int'(rco_hld),  mr[1]);
      cmp("load_hld", int'(load_hld), ml[1]);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rst, input logic en, input logic [2:0] m,
                       input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] lim);
    RESET = rst; ENABLE = en; MODO = m; D = d; LIMIT = lim;
  endtask

  // Literal check of clear-on-disable instance after an edge.
  task automatic lit(input string name, input int q, input int r, input int l);
    cmp({name, "_q"},    int'(q_clr),    q);
    cmp({name, "_rco"},  int'(rco_clr),  r);
    cmp({name, "_load"}, int'(load_clr), l);
  endtask

  initial begin
    drive(1'b1, 1'b1, 3'd0, '0, '0);
    #1;
    // Reset for two edges with ENABLE=1, mode up.
    step(); step();
    lit("reset", 0, 0, 0);
    RESET = 1'b0;
    step(); lit("up1_a", 1, 0, 0);
    step(); lit("up1_b", 2, 0, 0);
    step(); lit("up1_c", 3, 0, 0);

    // Load 0xFE, then count up across the wrap.
    MODO = 3'd4; D = 8'hFE;
    step(); lit("ld_fe", 8'hFE, 0, 1);
    MODO = 3'd0;
    step(); lit("wrap_ff", 8'hFF, 0, 0);
    step(); lit("wrap_00", 8'h00, 1, 0);
    step(); lit("wrap_01", 8'h01, 0, 0);

    // Load 1, then step down by 3 with borrow.
    MODO = 3'd4; D = 8'h01;
    step(); lit("ld_01", 1, 0, 1);
    MODO = 3'd3;
    step(); lit("dns_fe", 8'hFE, 1, 0);
    step(); lit("dns_fb", 8'hFB, 0, 0);

    // Modulo up, LIMIT=4 from 0.
    RESET = 1'b1; step(); RESET = 1'b0;
    MODO = 3'd6; LIMIT = 8'd4;
    step(); lit("mu_1", 1, 0, 0);
    step(); lit("mu_2", 2, 0, 0);
    step(); lit("mu_3", 3, 0, 0);
    step(); lit("mu_4", 4, 0, 0);
    step(); lit("mu_0", 0, 1, 0);
    step(); lit("mu_1b", 1, 0, 0);
    // Above-limit count wraps immediately.
    MODO = 3'd4; D = 8'd9;
    step(); lit("ld_9", 9, 0, 1);
    MODO = 3'd6;
    step(); lit("mu_over", 0, 1, 0);
    // LIMIT=0: stays at 0 with RCO held high.
    LIMIT = 8'd0;
    step(); lit("mu_lim0_a", 0, 1, 0);
    step(); lit("mu_lim0_b", 0, 1, 0);

    // Modulo down, LIMIT=4 from 2.
    MODO = 3'd4; D = 8'd2; LIMIT = 8'd4;
    step();
    MODO = 3'd7;
    step(); lit("md_1", 1, 0, 0);
    step(); lit("md_0", 0, 0, 0);
    step(); lit("md_4", 4, 1, 0);

    // Disable policy.
    MODO = 3'd4; D = 8'h05;
    step();
    ENABLE = 1'b0;
    step(); lit("dis_clr", 0, 0, 0);
    cmp("dis_hld_q1", int'(q_hld), 5);
    step(); cmp("dis_hld_q2", int'(q_hld), 5);
    step(); cmp("dis_hld_q3", int'(q_hld), 5);
    cmp("dis_hld_rco", int'(rco_hld), 0);
    cmp("dis_hld_load", int'(load_hld), 0);
    ENABLE = 1'b1; MODO = 3'd5;
    step(); cmp("hold_hld_q", int'(q_hld), 5);
    lit("hold_clr", 0, 0, 0);

    // Mid-count reset at the wrap edge.
    MODO = 3'd4; D = 8'hFF;
    step();
    MODO = 3'd0; RESET = 1'b1;
    step(); lit("midrst", 0, 0, 0);
    RESET = 1'b0;
    step(); lit("midrst_after", 1, 0, 0);

    // Randomized stimulus, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      RESET  = ($urandom_range(0, 63) == 0);
      ENABLE = ($urandom_range(0, 9) != 0);
      MODO   = 3'($urandom_range(0, 7));
      D      = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) LIMIT = WIDTH'($urandom);
      else LIMIT = WIDTH'($urandom_range(0, 12));
      step();
    end

    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
